// File: rtl/doodle_pkg.sv
// doodle_pkg: shared constants and types for the doodle sprite read engine.
// The sprite image is 30x29 pixels of 24-bit RGB, stored row-major in an 870-word RAM.
package doodle_pkg;

    localparam int SPRITE_W     = 30;
    localparam int SPRITE_H     = 29;
    localparam int SPRITE_DEPTH = 870;

    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  sprite_addr_t;

    // This colour is transparent: pixels of this colour are never reported as hits.
    localparam rgb_t KEY_COLOR = 24'hFF00FF;

endpackage

// File: rtl/doodle_addr_gen.sv
// doodle_addr_gen: combinational sprite bounds test and RAM address generation.
// If DOODLE_MIRROR_EN is defined, the i_mirror port exists and flips the column
// index so that one stored image serves both facings.
module doodle_addr_gen
    import doodle_pkg::*;
#(
    parameter int P_SPRITE_W = doodle_pkg::SPRITE_W,
    parameter int P_SPRITE_H = doodle_pkg::SPRITE_H
) (
    input  logic [9:0]   i_draw_x,
    input  logic [9:0]   i_draw_y,
    input  logic [9:0]   i_pos_x,
    input  logic [9:0]   i_pos_y,
`ifdef DOODLE_MIRROR_EN
    input  logic         i_mirror,
`endif
    output logic         o_inside,
    output sprite_addr_t o_addr
);

    // The bounds are compared in 11 bits. A sprite placed near x=1023 therefore
    // extends past the edge and does not wrap back to column 0.
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic [4:0]  w_col;
    logic [4:0]  w_row;
    logic [4:0]  w_col_eff;
    logic [9:0]  w_row_ext;
    logic [9:0]  w_addr_raw;

    // Bounds check, local row/col, and row*30+col computed as (row<<5)-(row<<1)+col
    always_comb begin
        w_x_end    = {1'b0, i_pos_x} + 11'(P_SPRITE_W);
        w_y_end    = {1'b0, i_pos_y} + 11'(P_SPRITE_H);
        o_inside   = ({1'b0, i_draw_x} >= {1'b0, i_pos_x}) && ({1'b0, i_draw_x} < w_x_end) &&
                     ({1'b0, i_draw_y} >= {1'b0, i_pos_y}) && ({1'b0, i_draw_y} < w_y_end);
        // Only the low 5 bits of the difference are needed, so subtract in 5 bits.
        w_col      = i_draw_x[4:0] - i_pos_x[4:0];
        w_row      = i_draw_y[4:0] - i_pos_y[4:0];
`ifdef DOODLE_MIRROR_EN
        w_col_eff  = i_mirror ? (5'(P_SPRITE_W - 1) - w_col) : w_col;
`else
        w_col_eff  = w_col;
`endif
        w_row_ext  = {5'b0, w_row};
        w_addr_raw = (w_row_ext << 5) - (w_row_ext << 1) + {5'b0, w_col_eff};
        o_addr     = o_inside ? w_addr_raw : '0;
    end

endmodule

// File: rtl/doodle_sprite_reader.sv
// doodle_sprite_reader: three-stage read pipeline from the VGA draw coordinate
// to an aligned sprite colour and hit flag.
//   stage 1: bounds check and address register
//   stage 2: the RAM's own registered read (hit flag delayed to match)
//   stage 3: colour-key test and output register
// The sprite position and facing are latched only on frame_start, so the
// sprite cannot tear in the middle of a frame.
// If DOODLE_MIRROR_EN is defined, a facing register is built and a latched
// facing_left=1 mirrors the sprite horizontally.
module doodle_sprite_reader
    import doodle_pkg::*;
#(
    parameter int   SPRITE_W  = doodle_pkg::SPRITE_W,
    parameter int   SPRITE_H  = doodle_pkg::SPRITE_H,
    parameter rgb_t KEY_COLOR = doodle_pkg::KEY_COLOR
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_start,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    input  logic [9:0]   SpriteX,
    input  logic [9:0]   SpriteY,
    input  logic         facing_left,
    output sprite_addr_t read_address,
    input  rgb_t         ram_data,
    output logic         sprite_hit,
    output rgb_t         pixel_color
);

    logic [9:0]   r_pos_x;
    logic [9:0]   r_pos_y;
    sprite_addr_t r_read_address;
    logic         r_hit1;
    logic         r_hit2;
    logic         r_sprite_hit;
    rgb_t         r_pixel_color;

    logic         w_inside;
    sprite_addr_t w_addr;
    logic         w_opaque;

`ifdef DOODLE_MIRROR_EN
    logic r_facing;

    // Latch the facing once per frame, together with the position
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_facing <= 1'b0;
        end else if (frame_start) begin
            r_facing <= facing_left;
        end
    end
`else
    logic w_unused_facing;
    assign w_unused_facing = facing_left;
`endif

    // Latch the sprite position once per frame. A coordinate presented in the
    // same cycle as frame_start still sees the old position.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else if (frame_start) begin
            r_pos_x <= SpriteX;
            r_pos_y <= SpriteY;
        end
    end

    doodle_addr_gen #(
        .P_SPRITE_W (SPRITE_W),
        .P_SPRITE_H (SPRITE_H)
    ) u_addr_gen (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_pos_x  (r_pos_x),
        .i_pos_y  (r_pos_y),
`ifdef DOODLE_MIRROR_EN
        .i_mirror (r_facing),
`endif
        .o_inside (w_inside),
        .o_addr   (w_addr)
    );

    // Stages 1 and 2: register the address and carry the in-sprite flag
    // alongside the RAM's one-cycle read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_read_address <= '0;
            r_hit1         <= 1'b0;
            r_hit2         <= 1'b0;
        end else begin
            r_read_address <= w_addr;
            r_hit1         <= w_inside;
            r_hit2         <= r_hit1;
        end
    end

    assign w_opaque = r_hit2 && (ram_data != KEY_COLOR);

    // Stage 3: key out transparent pixels and register the colour
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sprite_hit  <= 1'b0;
            r_pixel_color <= '0;
        end else begin
            r_sprite_hit  <= w_opaque;
            r_pixel_color <= w_opaque ? ram_data : 24'h000000;
        end
    end

    assign read_address = r_read_address;
    assign sprite_hit   = r_sprite_hit;
    assign pixel_color  = r_pixel_color;

endmodule
